// File: rtl/spi_burst_arbiter.sv
// spi_burst_arbiter
//   Shares one SPI byte engine among NUM_REQ requesters. Each requester owns
//   one slave select and issues multi-byte bursts. Arbitration is
//   round-robin. The granted ss_n is held low for the whole burst, with
//   programmable setup and hold times around the bytes.
//
// Ports
//   clk, rst_n    clock and asynchronous active-low reset
//   req           level request per requester, sampled only in IDLE
//   req_len       per-requester burst length minus one, latched at grant
//   tx_data       per-requester next TX byte
//   tx_pop        one-hot pulse when the owner's tx_data is consumed
//   rx_data       last received byte
//   rx_valid      one-hot pulse qualifying rx_data for its owner
//   done          one-hot pulse when a burst is finished and ss_n released
//   grant         one-hot current owner, zero when idle
//   ss_n          active-low slave selects, ss_n = ~grant
//   busy          high whenever a burst is in progress
//   eng_*         handshake with the shared SPI byte engine
//
// State table
//   state  | meaning
//   IDLE   | no owner, all ss_n high, round-robin pick on any req
//   SETUP  | ss_n low, CS_SETUP cycle delay before the first byte
//   SEND   | start the engine with the owner's byte once eng_busy is low
//   WAIT   | wait for eng_new_data, forward the byte, next byte or finish
//   HOLD   | ss_n still low for CS_HOLD cycles, then release and pulse done
`timescale 1ns/1ps
module spi_burst_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int LEN_W    = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    input  logic [NUM_REQ*8-1:0]     tx_data,
    output logic [NUM_REQ-1:0]       tx_pop,
    output logic [7:0]               rx_data,
    output logic [NUM_REQ-1:0]       rx_valid,
    output logic [NUM_REQ-1:0]       done,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       ss_n,
    output logic                     busy,
    output logic                     eng_start,
    output logic [7:0]               eng_data_in,
    input  logic                     eng_busy,
    input  logic                     eng_new_data,
    input  logic [7:0]               eng_data_out
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SEND,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   ptr;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   byte_cnt;
    logic [7:0]         dly_cnt;
    logic [NUM_REQ-1:0] sel_mask;

    logic               found;
    logic [IDX_W-1:0]   next_idx;
    int                 cand;

    // Round-robin search starting just after the last owner; the first
    // set request bit in that rotated order wins.
    always_comb begin
        found    = 1'b0;
        next_idx = ptr;
        cand     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found    = 1'b1;
                next_idx = cand[IDX_W-1:0];
            end
        end
    end

    assign sel_mask    = NUM_REQ'(1) << idx;
    assign busy        = (state != S_IDLE);
    assign eng_start   = (state == S_SEND) && !eng_busy;
    assign tx_pop      = eng_start ? sel_mask : '0;
    // Forced to zero while idle so the engine bus is quiet between bursts.
    assign eng_data_in = busy ? tx_data[{idx, 3'b000} +: 8] : 8'h00;
    assign ss_n        = ~grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            ptr      <= IDX_W'(NUM_REQ - 1);
            len      <= '0;
            byte_cnt <= '0;
            dly_cnt  <= '0;
            grant    <= '0;
            rx_data  <= '0;
            rx_valid <= '0;
            done     <= '0;
        end else begin
            rx_valid <= '0;
            done     <= '0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        idx      <= next_idx;
                        ptr      <= next_idx;
                        len      <= req_len[int'(next_idx) * LEN_W +: LEN_W];
                        byte_cnt <= '0;
                        dly_cnt  <= 8'(CS_SETUP - 1);
                        grant    <= NUM_REQ'(1) << next_idx;
                        state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (dly_cnt == 8'd0) begin
                        state <= S_SEND;
                    end else begin
                        dly_cnt <= dly_cnt - 8'd1;
                    end
                end
                S_SEND: begin
                    if (!eng_busy) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (eng_new_data) begin
                        rx_data  <= eng_data_out;
                        rx_valid <= sel_mask;
                        // The length compare ends the burst before byte_cnt
                        // could wrap, even at the maximum length.
                        if (byte_cnt == len) begin
                            dly_cnt <= 8'(CS_HOLD - 1);
                            state   <= S_HOLD;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            state    <= S_SEND;
                        end
                    end
                end
                S_HOLD: begin
                    if (dly_cnt == 8'd0) begin
                        grant <= '0;
                        done  <= sel_mask;
                        state <= S_IDLE;
                    end else begin
                        dly_cnt <= dly_cnt - 8'd1;
                    end
                end
                default: begin
                    grant <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_burst_arbiter.sv
`timescale 1ns/1ps
module tb_spi_burst_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int LEN_W    = 4;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int MAXB     = 32;
    localparam int MAXK     = 20;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic [NUM_REQ*8-1:0]     tx_data;
    logic [NUM_REQ-1:0]       tx_pop;
    logic [7:0]               rx_data;
    logic [NUM_REQ-1:0]       rx_valid;
    logic [NUM_REQ-1:0]       done;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       ss_n;
    logic                     busy;
    logic                     eng_start;
    logic [7:0]               eng_data_in;
    logic                     eng_busy;
    logic                     eng_new_data;
    logic [7:0]               eng_data_out;

    spi_burst_arbiter #(
        .NUM_REQ (NUM_REQ),
        .LEN_W   (LEN_W),
        .CS_SETUP(CS_SETUP),
        .CS_HOLD (CS_HOLD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_len     (req_len),
        .tx_data     (tx_data),
        .tx_pop      (tx_pop),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .done        (done),
        .grant       (grant),
        .ss_n        (ss_n),
        .busy        (busy),
        .eng_start   (eng_start),
        .eng_data_in (eng_data_in),
        .eng_busy    (eng_busy),
        .eng_new_data(eng_new_data),
        .eng_data_out(eng_data_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // client byte sources and the simple engine model
    logic [7:0] tx_mem [NUM_REQ][64];
    int         tx_ptr [NUM_REQ];
    int         eng_cnt, stall_cnt;
    logic [7:0] eng_byte;
    bit         stall_next, stall_mark, stray_nd;
    logic       s_start;
    logic [7:0] s_data;
    logic [NUM_REQ-1:0] s_pop;

    // per-burst event log
    int   nb, tot_done;
    logic [NUM_REQ-1:0] prev_grant, req_edge;
    logic [NUM_REQ*LEN_W-1:0] lenv_edge;
    logic [NUM_REQ-1:0] req_seen [MAXB];
    logic [NUM_REQ*LEN_W-1:0] lenv_seen [MAXB];
    int   g_own [MAXB], g_cyc [MAXB], d_own [MAXB], d_cyc [MAXB], n_done [MAXB];
    int   low_cnt [MAXB], n_st [MAXB], n_nd [MAXB], n_rx [MAXB];
    int   st_cyc [MAXB][MAXK], nd_cyc [MAXB][MAXK], rx_cyc [MAXB][MAXK];
    int   rx_own [MAXB][MAXK], rx_byte [MAXB][MAXK];
    bit   stall_on [MAXB][MAXK];

    // reference model state
    int ptr_m;
    int cons_m [NUM_REQ];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int oh2i(input logic [NUM_REQ-1:0] v);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic drive_tx();
        for (int i = 0; i < NUM_REQ; i++) begin
            tx_data[i*8 +: 8] = tx_mem[i][tx_ptr[i] % 64];
        end
    endtask

    task automatic clear_logs();
        nb = 0; tot_done = 0; prev_grant = '0; ptr_m = NUM_REQ - 1;
        for (int i = 0; i < NUM_REQ; i++) begin
            cons_m[i] = 0; tx_ptr[i] = 0;
        end
        for (int b = 0; b < MAXB; b++) begin
            n_st[b] = 0; n_nd[b] = 0; n_rx[b] = 0; n_done[b] = 0; low_cnt[b] = 0;
            for (int k = 0; k < MAXK; k++) begin
                st_cyc[b][k] = 0; nd_cyc[b][k] = 0; rx_cyc[b][k] = 0;
                rx_own[b][k] = 0; rx_byte[b][k] = 0; stall_on[b][k] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        int cb;
        logic [NUM_REQ-1:0] ng, pop_exp;
        @(posedge clk); #1;
        cyc++;
        req_edge  = req;
        lenv_edge = req_len;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (s_pop[i]) tx_ptr[i]++;
        end
        eng_new_data = stray_nd;
        stray_nd = 1'b0;
        if (stall_cnt > 0) stall_cnt--;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                eng_new_data = 1'b1;
                eng_data_out = eng_byte;
                if (stall_next) begin
                    stall_cnt  = 6;
                    stall_next = 1'b0;
                    stall_mark = 1'b1;
                end
            end
        end
        if (s_start) begin
            eng_cnt  = $urandom_range(1, 3);
            eng_byte = s_data;
        end
        eng_busy = (eng_cnt > 0) || (stall_cnt > 0);
        drive_tx();
        @(negedge clk);
        s_start = eng_start; s_data = eng_data_in; s_pop = tx_pop;
        ng      = ~grant;
        pop_exp = eng_start ? grant : '0;
        check("ssn_vs_grant", 32'(ss_n), 32'(ng));
        check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
        check("busy_vs_grant", 32'(busy), 32'(grant != '0));
        check("pop_vs_start", 32'(tx_pop), 32'(pop_exp));
        if (eng_busy) check("start_while_busy", 32'(eng_start), 32'd0);
        if (grant != '0 && prev_grant == '0 && nb < MAXB) begin
            g_own[nb] = oh2i(grant); g_cyc[nb] = cyc;
            req_seen[nb] = req_edge; lenv_seen[nb] = lenv_edge;
            nb++;
        end
        cb = (nb > 0) ? nb - 1 : 0;
        if (grant != '0) low_cnt[cb]++;
        if (eng_start) begin
            if (n_st[cb] < MAXK) st_cyc[cb][n_st[cb]] = cyc;
            n_st[cb]++;
        end
        if (eng_new_data && grant != '0) begin
            if (n_nd[cb] < MAXK) begin
                nd_cyc[cb][n_nd[cb]] = cyc;
                stall_on[cb][n_nd[cb]] = stall_mark;
            end
            stall_mark = 1'b0;
            n_nd[cb]++;
        end
        if (rx_valid != '0) begin
            if (n_rx[cb] < MAXK) begin
                rx_cyc[cb][n_rx[cb]] = cyc; rx_own[cb][n_rx[cb]] = oh2i(rx_valid);
                rx_byte[cb][n_rx[cb]] = int'(rx_data);
            end
            n_rx[cb]++;
        end
        if (done != '0) begin
            d_own[cb] = oh2i(done); d_cyc[cb] = cyc;
            n_done[cb]++; tot_done++;
        end
        prev_grant = grant;
    endtask

    task automatic wait_grant(input string tag, input int budget);
        int n = 0;
        while (grant == '0 && n < budget) begin
            tick(); n++;
        end
        check({tag, "_grant_seen"}, 32'(grant != '0), 32'd1);
    endtask

    task automatic run_until(input string tag, input int target, input int budget);
        int n = 0;
        while (tot_done < target && n < budget) begin
            tick(); n++;
        end
        check({tag, "_done_reached"}, 32'(tot_done >= target), 32'd1);
    endtask

    // Expected behaviour of each burst derived from request snapshots:
    // round-robin owner, byte count, bytes in client order, setup/hold spacing.
    task automatic check_bursts(input int first, input int last, input bit tight);
        for (int b = first; b <= last; b++) begin
            int o, L;
            o = -1;
            for (int k = 1; k <= NUM_REQ; k++) begin
                int c;
                c = (ptr_m + k) % NUM_REQ;
                if (o < 0 && req_seen[b][c]) o = c;
            end
            check("owner", 32'(g_own[b]), 32'(o));
            if (o >= 0) begin
                ptr_m = o;
                L = int'(lenv_seen[b][o*LEN_W +: LEN_W]) + 1;
                check("starts", 32'(n_st[b]), 32'(L));
                check("rx_count", 32'(n_rx[b]), 32'(L));
                check("done_count", 32'(n_done[b]), 32'd1);
                check("done_owner", 32'(d_own[b]), 32'(o));
                check("setup_cycles", 32'(st_cyc[b][0] - g_cyc[b]), 32'(CS_SETUP));
                check("hold_cycles", 32'(d_cyc[b] - nd_cyc[b][L-1]), 32'(CS_HOLD + 1));
                check("ss_low_cycles", 32'(low_cnt[b]), 32'(d_cyc[b] - g_cyc[b]));
                for (int k = 0; k < L; k++) begin
                    check("rx_byte", 32'(rx_byte[b][k]), 32'(tx_mem[o][(cons_m[o] + k) % 64]));
                    check("rx_owner", 32'(rx_own[b][k]), 32'(o));
                    check("rx_latency", 32'(rx_cyc[b][k] - nd_cyc[b][k]), 32'd1);
                    if (k > 0)
                        check("restart_gap", 32'(st_cyc[b][k] - nd_cyc[b][k-1]),
                              32'(stall_on[b][k-1] ? 6 : 1));
                end
                cons_m[o] += L;
                if (tight && b < last)
                    check("idle_gap", 32'(g_cyc[b+1] - d_cyc[b]), 32'd1);
            end
        end
    endtask

    task automatic reset_outputs_check(input string tag);
        check({tag, "_ss_n"}, 32'(ss_n), 32'hF);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_tx_pop"}, 32'(tx_pop), 32'd0);
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        check({tag, "_rx_data"}, 32'(rx_data), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_eng_start"}, 32'(eng_start), 32'd0);
        check({tag, "_eng_data_in"}, 32'(eng_data_in), 32'd0);
    endtask

    task automatic clear_engine();
        eng_cnt = 0; stall_cnt = 0; eng_busy = 1'b0; eng_new_data = 1'b0;
        stall_next = 1'b0; stall_mark = 1'b0; stray_nd = 1'b0;
        s_start = 1'b0; s_data = '0; s_pop = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        rst_n = 1'b0; req = '0; req_len = '0; eng_data_out = '0;
        for (int i = 0; i < NUM_REQ; i++)
            for (int k = 0; k < 64; k++) tx_mem[i][k] = 8'($urandom_range(1, 255));
        tx_mem[0][0] = 8'hA5; tx_mem[0][1] = 8'h3C; tx_mem[0][2] = 8'hF0;
        clear_engine();
        clear_logs();
        drive_tx();
        repeat (3) @(negedge clk);
        reset_outputs_check("reset");
        rst_n = 1'b1;

        // single burst, three bytes to requester 0
        req_len = '0; req_len[0 +: LEN_W] = 4'd2; req = 4'b0001;
        wait_grant("single", 20);
        req = '0;
        run_until("single", 1, 200);
        repeat (4) tick();
        check("single_no_regrant", 32'(nb), 32'd1);
        check_bursts(0, 0, 1'b0);

        // round-robin with every requester asking continuously
        req_len = '0; req = 4'b1111;
        run_until("rr", tot_done + 5, 400);
        req = '0;
        repeat (4) tick();
        check_bursts(1, 5, 1'b1);

        // randomized request patterns, some with an engine stall
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < NUM_REQ; i++) req_len[i*LEN_W +: LEN_W] = 4'($urandom_range(1, 3));
            req = 4'($urandom_range(1, 15));
            stall_next = ($urandom_range(0, 1) == 1);
            wait_grant("rand", 20);
            req = '0;
            run_until("rand", tot_done + 1, 300);
            stall_next = 1'b0;
            check_bursts(nb - 1, nb - 1, 1'b0);
        end

        // maximum length with request changes during the burst
        req_len = 16'($urandom); req_len[2*LEN_W +: LEN_W] = 4'hF; req = 4'b0100;
        wait_grant("maxlen", 20);
        req = 4'b1011; req_len = 16'($urandom);
        repeat (5) tick();
        req = '0;
        run_until("maxlen", tot_done + 1, 600);
        check_bursts(nb - 1, nb - 1, 1'b0);

        // reset in the middle of the second byte
        req_len = '0; req_len[1*LEN_W +: LEN_W] = 4'd5; req = 4'b0010;
        wait_grant("rst", 20);
        req = '0;
        b0 = 0;
        while (n_st[nb-1] < 2 && b0 < 100) begin
            tick(); b0++;
        end
        check("rst_second_start", 32'(n_st[nb-1]), 32'd2);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        reset_outputs_check("async_rst");
        clear_engine();
        clear_logs();
        drive_tx();
        @(negedge clk);
        rst_n = 1'b1;
        stray_nd = 1'b1; eng_data_out = 8'h77;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stray_rx_valid", 32'(rx_valid), 32'd0);
        end
        for (int i = 0; i < NUM_REQ; i++) req_len[i*LEN_W +: LEN_W] = 4'($urandom_range(0, 1));
        req = 4'b1111;
        wait_grant("post_rst", 20);
        req = '0;
        run_until("post_rst", 1, 200);
        check("post_rst_owner0", 32'(g_own[0]), 32'd0);
        check_bursts(0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_burst_arbiter.md
# spi_burst_arbiter

Shares one SPI byte engine (start/data_in/busy/new_data/data_out handshake) among NUM_REQ requesters. Each requester owns one slave select and issues multi-byte bursts. The block arbitrates round-robin and holds the granted slave's ss_n low for the whole burst, with programmable setup and hold. It feeds TX bytes to the engine one at a time and routes each received byte back to the owner. It sits between the per-slave client logic and the SPI byte engine.

## Interface
- NUM_REQ, 4: requester/slave count, 2..8
- LEN_W, 4: burst-length field width; max burst 2^LEN_W bytes
- CS_SETUP, 2: cycles ss_n is low before the first eng_start, 1..255
- CS_HOLD, 2: cycles ss_n stays low after the last byte completes, 1..255

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  level request per requester; sampled only in IDLE
- req_len  in  NUM_REQ*LEN_W  byte count minus 1 per requester, slice i = [i*LEN_W +: LEN_W]; latched at grant
- tx_data  in  NUM_REQ*8  next TX byte per requester, slice i = [i*8 +: 8]
- tx_pop  out  NUM_REQ  one-hot pulse: owner's tx_data consumed this cycle; owner presents the next byte by the next SEND
- rx_data  out  8  last received byte
- rx_valid  out  NUM_REQ  one-hot 1-cycle pulse qualifying rx_data for its owner
- done  out  NUM_REQ  one-hot 1-cycle pulse: burst finished, ss_n released
- grant  out  NUM_REQ  one-hot current owner; 0 when idle
- ss_n  out  NUM_REQ  active-low slave selects; ss_n[i] = ~grant[i]
- busy  out  1  state != IDLE
- eng_start  out  1  engine start; = (state==SEND) & ~eng_busy
- eng_data_in  out  8  = tx_data slice of current owner
- eng_busy  in  1  engine busy
- eng_new_data  in  1  engine byte-complete pulse
- eng_data_out  in  8  engine received byte, valid with eng_new_data

## Operation
- States: IDLE, SETUP, SEND, WAIT, HOLD.
- **IDLE:** grant=0, all ss_n high. If any req bit is set, select the first set bit searching ptr+1, ptr+2, … (mod NUM_REQ). Latch idx, len=req_len[idx] and byte_cnt=0, then go to SETUP. Update ptr to idx. Reset value of ptr is NUM_REQ-1, so requester 0 wins first.
- **SETUP:** ss_n[idx] is low. A counter runs CS_SETUP cycles, then the FSM goes to SEND.
- **SEND:** when eng_busy is low, eng_start=1 and tx_pop[idx]=1 for exactly that cycle, then go to WAIT. When eng_busy is high, stay in SEND with no start.
- **WAIT:** on eng_new_data, register rx_data=eng_data_out and pulse rx_valid[idx] the next cycle.
  - If byte_cnt==len, go to HOLD.
  - Otherwise increment byte_cnt and go to SEND.
  - eng_new_data outside WAIT is ignored.
- **HOLD:** CS_HOLD cycles with ss_n still low, then go to IDLE. done[idx] pulses in the first IDLE cycle.
- Changes to req or req_len after grant do not affect the burst in progress. Bursts are never aborted except by reset.
- Widths: byte_cnt is LEN_W bits and never wraps, because the comparison with len ends the burst first. Delay counters are 8 bits.

## Timing
- Reset (async assert, sync release): state=IDLE, ss_n all 1, and every other output 0: grant, tx_pop, rx_valid, rx_data, done, busy, eng_start, eng_data_in.
- Reset mid-burst releases ss_n immediately. A pending eng_new_data is then discarded.
- Burst timeline, with req seen in IDLE at cycle t and eng_busy low:
  - grant and ss_n[idx] low at t+1.
  - eng_start at t+1+CS_SETUP.
  - eng_new_data at cycle w gives rx_valid at w+1 and the next eng_start at w+1.
  - Last eng_new_data at cycle w gives HOLD over w+1..w+CS_HOLD, then IDLE, ss_n high and done at w+CS_HOLD+1.
- The IDLE cycle is the minimum 1-cycle all-deasserted gap between bursts. A new grant can appear the cycle after done.
- Simultaneous requests are served strictly round-robin. A single continuous requester is re-granted after one IDLE cycle.

## Test plan
- **Single burst:** NUM_REQ=4, CS_SETUP=2, CS_HOLD=2. req=0001, req_len[0]=2, TX bytes A5,3C,F0, engine with loopback miso.
  - 3 eng_start pulses and 3 tx_pop[0] pulses.
  - rx bytes A5,3C,F0 on rx_valid[0].
  - ss_n[0] low from grant through HOLD; done[0] once.
  - Setup and hold cycle counts match CS_SETUP and CS_HOLD.
- **Round-robin:** req=1111 held, each req_len=0.
  - Grant order 0,1,2,3,0.
  - Exactly one IDLE cycle with ss_n=1111 between bursts.
  - ss_n is never low for two slaves at once.
- **Engine busy stall:** hold eng_busy high for 5 cycles on SEND entry.
  - eng_start and tx_pop stay 0 until eng_busy falls, then pulse once.
- **Max length:** req_len=F → 16 bytes, byte_cnt ends without wrap, done after the 16th rx_valid. Requests that change mid-burst are ignored.
- **Reset mid-burst:** assert rst_n low during WAIT of byte 2.
  - All outputs take reset values asynchronously.
  - After release, a stray eng_new_data causes no rx_valid.
  - The next grant goes to requester 0.
